// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC sequencer for the 10-bit control core.
// Owns the PC, drives the return-address stack and tracks its depth.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   hold               freeze PC, accept no command (RUN only)
//   jump, call, ret    commands, priority ret > call > jump > increment
//   target             jump/call destination
//   stack_dout         stack pop data (stored value + 1)
//   pc                 current program counter
//   busy               high while a RET is in flight (and in TRAP)
//   stack_push/pop     one-cycle pulses to the stack
//   stack_din          value pushed (PC at the CALL)
//   depth              live stack entries, 0..DEPTH
//   error              sticky overflow/underflow flag
//
// Build option: PC_TRAP_EN -- overflow/underflow enters a TRAP state that
// only reset leaves; otherwise the fault is flagged and execution continues.

module pc_sequencer #(
    parameter int            AW       = 10,
    parameter int            DEPTH    = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    localparam int           DW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          jump,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] target,
    input  logic [AW-1:0] stack_dout,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          stack_push,
    output logic          stack_pop,
    output logic [AW-1:0] stack_din,
    output logic [DW-1:0] depth,
    output logic          error
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_POP  = 2'd1,
        ST_LOAD = 2'd2
`ifdef PC_TRAP_EN
        ,
        ST_TRAP = 2'd3
`endif
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic          r_busy;
    logic          r_push;
    logic          r_pop;
    logic [AW-1:0] r_din;
    logic [DW-1:0] r_depth;
    logic          r_err;

    logic          w_under;
    logic          w_over;

    assign w_under = (r_depth == '0);
    assign w_over  = (r_depth == DW'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_busy  <= 1'b0;
            r_push  <= 1'b0;
            r_pop   <= 1'b0;
            r_din   <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-issued below.
            r_push <= 1'b0;
            r_pop  <= 1'b0;
            unique case (r_state)
                ST_RUN: begin
                    if (hold) begin
                        r_pc <= r_pc;
                    end else if (ret) begin
                        if (w_under) begin
                            r_err  <= 1'b1;
                            r_busy <= 1'b1;
`ifdef PC_TRAP_EN
                            r_state <= ST_TRAP;
`else
                            // Depth saturates at 0; the stack wraps.
                            r_pop   <= 1'b1;
                            r_state <= ST_POP;
`endif
                        end else begin
                            r_pop   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_depth <= r_depth - DW'(1);
                            r_state <= ST_POP;
                        end
                    end else if (call) begin
                        if (w_over) begin
                            r_err <= 1'b1;
`ifdef PC_TRAP_EN
                            r_busy  <= 1'b1;
                            r_state <= ST_TRAP;
`else
                            // Depth saturates at DEPTH; the stack wraps.
                            r_push <= 1'b1;
                            r_din  <= r_pc;
                            r_pc   <= target;
`endif
                        end else begin
                            r_push  <= 1'b1;
                            r_din   <= r_pc;
                            r_pc    <= target;
                            r_depth <= r_depth + DW'(1);
                        end
                    end else if (jump) begin
                        r_pc <= target;
                    end else begin
                        r_pc <= r_pc + AW'(1);
                    end
                end
                ST_POP: begin
                    // Stack registers its output on this edge.
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_pc    <= stack_dout;
                    r_busy  <= 1'b0;
                    r_state <= ST_RUN;
                end
`ifdef PC_TRAP_EN
                ST_TRAP: begin
                    r_busy <= 1'b1;
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign pc         = r_pc;
    assign busy       = r_busy;
    assign stack_push = r_push;
    assign stack_pop  = r_pop;
    assign stack_din  = r_din;
    assign depth      = r_depth;
    assign error      = r_err;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC sequencer for the small 10-bit control core: owns the program counter and drives the 16-entry return-address stack directly downstream. On CALL it pushes the current PC and jumps. On RET it pops the stack, whose output is stored+1, and resumes at the instruction after the call. It keeps its own depth count so stack overflow and underflow are caught here; the stack itself cannot detect them.

## Interface
- AW, 10, PC and address width; matches stack data width.
- DEPTH, 16, stack entries; must equal the stack depth.
- RESET_PC, 0, PC value after reset.

- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- hold  in  1  freeze: no PC update, no new command accepted.
- jump  in  1  load PC with target.
- call  in  1  push PC to stack, load PC with target.
- ret  in  1  pop stack, load PC with popped value.
- target  in  AW  jump/call destination.
- stack_dout  in  AW  stack outpop (stored value + 1).
- pc  out  AW  current program counter.
- busy  out  1  high while a RET sequence is in progress.
- stack_push  out  1  one-cycle push pulse to stack.
- stack_pop  out  1  one-cycle pop pulse to stack.
- stack_din  out  AW  value pushed (PC at the CALL).
- depth  out  clog2(DEPTH)+1  live entries, 0..DEPTH.
- error  out  1  sticky overflow/underflow flag.

## Operation
- All outputs are registered.
- Reset values: pc=RESET_PC, state=RUN, busy=0, stack_push=0, stack_pop=0, stack_din=0, depth=0, error=0.
- FSM states: RUN, POP, LOAD, TRAP (TRAP exists only with PC_TRAP_EN).
- RUN, command priority ret > call > jump > increment. Simultaneous commands are resolved by this priority; lower-priority commands are dropped.
  - hold=1: all state held, nothing accepted.
  - ret: stack_pop<=1, depth<=depth-1, state<=POP, pc unchanged.
  - call: stack_push<=1, stack_din<=pc, depth<=depth+1, pc<=target.
  - jump: pc<=target.
  - no command: pc<=pc+1, mod 2^AW; 2^AW-1 wraps to 0.
- POP: stack_pop<=0, state<=LOAD. Commands and hold are ignored.
- LOAD: pc<=stack_dout, state<=RUN. Commands and hold are ignored.
- busy=1 in POP and LOAD. Upstream must not present commands while busy; any that arrive are dropped.
- Underflow: ret at depth=0. Overflow: call at depth=DEPTH. Either sets error=1. error stays set until reset.
- Reset mid-RET or mid-CALL: returns to the reset values next edge. Any pulse in flight is cleared. The stack's reset must be driven from the same reset net.

## Timing
- Increment, jump and call: pc updates at the edge after the command is sampled, i.e. 1 cycle.
- stack_push is high for exactly the cycle after a call is sampled, with stack_din stable.
- ret sampled at edge N:
  - stack_pop high during cycle N..N+1.
  - state LOAD during cycle N+1..N+2, where stack_dout must be valid.
  - pc = stack_dout from edge N+2.
  - The next command can be accepted at edge N+3. RET costs 3 cycles; everything else costs 1.
- No back-to-back push/pop glitches: stack_push and stack_pop are never high together.

## Configuration
- PC_TRAP_EN defined:
  - Overflow or underflow sets error, suppresses the push/pop pulse, leaves depth and pc unchanged, and enters TRAP.
  - TRAP holds pc, keeps busy=1, and leaves only on reset.
- PC_TRAP_EN undefined:
  - error is still set, but the pulse is issued as normal.
  - depth saturates at 0/DEPTH, and execution continues; the stack pointer wraps silently.

## Test plan
- Reset then 5 idle cycles -> pc 0,1,2,3,4,5; depth=0; push/pop never asserted.
- pc=0x010, call target=0x200 -> next cycle stack_push=1, stack_din=0x010, pc=0x200, depth=1.
- Continuing from the previous scenario, stub stack returns 0x011; ret at pc=0x203 -> stack_pop for 1 cycle, busy 2 cycles, pc=0x011 three edges after ret, depth=0.
- jump+call+ret in the same cycle at depth 1 -> only ret executes (pop pulse, no push). hold=1 for 3 cycles -> pc frozen.
- pc=0x3FF idle -> pc=0x000. Reset asserted during POP -> pc=RESET_PC, stack_pop=0, busy=0 next cycle.
- 17 calls, then ret at depth 0 from a fresh reset:
  - With PC_TRAP_EN: error=1, no 17th push, busy stays 1.
  - Without PC_TRAP_EN: error=1, pc keeps advancing, depth=16.
